// File: rtl/commit_trace_tx_if.sv
// Trace record link between the commit-trace transmitter and the off-core receiver.
// The transmitter is the master: it offers a record with valid and the receiver accepts it with ready.
interface commit_trace_tx_if;
    logic        trace_valid;
    logic        trace_ready;
    logic [3:0]  trace_kind;
    logic [15:0] trace_a;
    logic [15:0] trace_b;

    modport master (
        output trace_valid,
        output trace_kind,
        output trace_a,
        output trace_b,
        input  trace_ready
    );

    modport slave (
        input  trace_valid,
        input  trace_kind,
        input  trace_a,
        input  trace_b,
        output trace_ready
    );
endinterface

// File: rtl/commit_trace_tx.sv
// Commit-trace transmitter: turns per-cycle commit events into fixed-format trace
// records and queues them in a FIFO drained over a valid/ready link.
// Optional feature macro: TRACE_SUMMARY_EN adds performance counters, the DUMP
// state and summary records of kinds 4..9 appended after the HALT record.
module commit_trace_tx #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_wr,
    input  logic [2:0]  reg_sel,
    input  logic [15:0] reg_data,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic [15:0] mem_wdata,
    input  logic        halt,
    input  logic        icache_req,
    input  logic        icache_hit,
    input  logic        dcache_req,
    input  logic        dcache_hit,
    output logic        commit_stall,
    output logic        trace_done,
    commit_trace_tx_if.master trace
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DUMP,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [3:0]  kind;
        logic [15:0] a;
        logic [15:0] b;
    } rec_t;

    state_t        state_q, state_d;
    rec_t          fifoMem_q [DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] freeSlots;

    logic          sampled;
    logic          popFire;
    logic          validOut;
    rec_t          headRec;

    logic [3:0]    pushEn;
    rec_t          pushRec [4];
    logic [PW-1:0] pushOfs [4];
    logic [2:0]    pushCnt;

`ifdef TRACE_SUMMARY_EN
    logic [CNT_W-1:0] cnt_q [6];
    logic [5:0]       cntInc;
    logic [2:0]       dumpIdx_q, dumpIdx_d;
    logic [CNT_W-1:0] sumVal;
    logic             dumpPush;
`else
    logic             unusedStrobes;
    logic [CNT_W-1:0] unusedCntWidth;
    assign unusedStrobes  = ^{icache_req, icache_hit, dcache_req, dcache_hit};
    assign unusedCntWidth = '0;
`endif

    // Status and link outputs, all derived from registered state so the producer never sees a comb loop.
    always_comb begin
        freeSlots    = CW'(DEPTH) - count_q;
        commit_stall = (freeSlots < CW'(4)) || (state_q != ST_RUN);
        sampled      = (state_q == ST_RUN) && !commit_stall;
        trace_done   = (state_q == ST_DONE);
        validOut     = (count_q != '0);
        headRec      = fifoMem_q[rdPtr_q];
        popFire      = validOut && trace.trace_ready;
    end

    assign trace.trace_valid = validOut;
    assign trace.trace_kind  = validOut ? headRec.kind : 4'h0;
    assign trace.trace_a     = validOut ? headRec.a    : 16'h0;
    assign trace.trace_b     = validOut ? headRec.b    : 16'h0;

`ifdef TRACE_SUMMARY_EN
    // Counter increment strobes in summary-record order: CYC, INST, DCHIT, ICHIT, DCREQ, ICREQ.
    always_comb begin
        cntInc    = '0;
        cntInc[0] = (state_q == ST_RUN);
        cntInc[1] = sampled && (halt || reg_wr || mem_wr);
        cntInc[2] = sampled && dcache_hit;
        cntInc[3] = sampled && icache_hit;
        cntInc[4] = sampled && dcache_req;
        cntInc[5] = sampled && icache_req;
    end

    // Saturating performance counters; they stop moving once the FSM leaves RUN, freezing the summary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 6; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (cntInc[k] && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + CNT_W'(1);
            end
        end
    end

    // Select the counter whose summary record is emitted this DUMP cycle.
    always_comb begin
        sumVal   = '0;
        dumpPush = (state_q == ST_DUMP) && (freeSlots != '0);
        case (dumpIdx_q)
            3'd0:    sumVal = cnt_q[0];
            3'd1:    sumVal = cnt_q[1];
            3'd2:    sumVal = cnt_q[2];
            3'd3:    sumVal = cnt_q[3];
            3'd4:    sumVal = cnt_q[4];
            3'd5:    sumVal = cnt_q[5];
            default: sumVal = '0;
        endcase
        dumpIdx_d = dumpIdx_q;
        if (dumpPush) dumpIdx_d = (dumpIdx_q == 3'd5) ? 3'd0 : dumpIdx_q + 3'd1;
    end

    // Summary record index register.
    always_ff @(posedge clk) begin
        if (!rst_n) dumpIdx_q <= 3'd0;
        else        dumpIdx_q <= dumpIdx_d;
    end
`endif

    // Build up to four records per cycle and pack the enabled ones into consecutive FIFO slots.
    always_comb begin
        pushEn  = '0;
        pushCnt = '0;
        for (int k = 0; k < 4; k++) begin
            pushRec[k] = '0;
            pushOfs[k] = '0;
        end
        if (sampled) begin
            pushEn     = {halt, mem_wr, mem_rd, reg_wr};
            pushRec[0] = {4'd0, 13'b0, reg_sel, reg_data};
            pushRec[1] = {4'd1, mem_addr, mem_rdata};
            pushRec[2] = {4'd2, mem_addr, mem_wdata};
            pushRec[3] = {4'd3, 16'h0, 16'h0};
        end
`ifdef TRACE_SUMMARY_EN
        else if (dumpPush) begin
            pushEn[0]  = 1'b1;
            pushRec[0] = {4'd4 + {1'b0, dumpIdx_q}, sumVal[31:16], sumVal[15:0]};
        end
`endif
        for (int k = 0; k < 4; k++) begin
            pushOfs[k] = PW'(pushCnt);
            pushCnt    = pushCnt + {2'b0, pushEn[k]};
        end
    end

    // FIFO pointer and occupancy next-state; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wrPtr_d = wrPtr_q + PW'(pushCnt);
        rdPtr_d = rdPtr_q + PW'(popFire);
        count_d = count_q + CW'(pushCnt) - CW'(popFire);
    end

    // FIFO bookkeeping registers; reset flushes any queued records.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates what is visible.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (pushEn[k]) fifoMem_q[wrPtr_q + pushOfs[k]] <= pushRec[k];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // FSM next state: RUN until halt, optional summary dump, drain the FIFO, then stay done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (sampled && halt) begin
`ifdef TRACE_SUMMARY_EN
                    state_d = ST_DUMP;
`else
                    state_d = ST_DRAIN;
`endif
                end
            end
            ST_DUMP: begin
`ifdef TRACE_SUMMARY_EN
                if (dumpPush && (dumpIdx_q == 3'd5)) state_d = ST_DRAIN;
`else
                state_d = ST_DRAIN;
`endif
            end
            ST_DRAIN: begin
                if (count_q == '0) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_RUN;
        endcase
    end

endmodule

// File: tb/tb_commit_trace_tx.sv
// Self-checking bench for commit_trace_tx: directed scenarios followed by a randomized
// phase, all compared against a queue-based reference model of the record stream.
// Honours TRACE_SUMMARY_EN the same way as the design.
module tb_commit_trace_tx;

    localparam int DEPTH  = 8;
    localparam int M_RUN  = 0;
    localparam int M_DUMP = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        regWr;
    logic [2:0]  regSel;
    logic [15:0] regData;
    logic        memRd;
    logic        memWr;
    logic [15:0] memAddr;
    logic [15:0] memRdata;
    logic [15:0] memWdata;
    logic        haltIn;
    logic        icacheReq;
    logic        icacheHit;
    logic        dcacheReq;
    logic        dcacheHit;
    logic        traceReady;
    logic        commitStall;
    logic        traceDone;

    commit_trace_tx_if link ();
    assign link.trace_ready = traceReady;

    commit_trace_tx #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg_wr       (regWr),
        .reg_sel      (regSel),
        .reg_data     (regData),
        .mem_rd       (memRd),
        .mem_wr       (memWr),
        .mem_addr     (memAddr),
        .mem_rdata    (memRdata),
        .mem_wdata    (memWdata),
        .halt         (haltIn),
        .icache_req   (icacheReq),
        .icache_hit   (icacheHit),
        .dcache_req   (dcacheReq),
        .dcache_hit   (dcacheHit),
        .commit_stall (commitStall),
        .trace_done   (traceDone),
        .trace        (link)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int passCount;
    int failCount;
    int totalCount;

    logic [35:0] expQ [$];
    logic [35:0] rxLog [$];
    int          mState;
`ifdef TRACE_SUMMARY_EN
    longint unsigned mCnt [6];
    int              mDumpIdx;
`endif

    function automatic logic [35:0] rec(input logic [3:0] k, input logic [15:0] a, input logic [15:0] b);
        return {k, a, b};
    endfunction

    task automatic checkOutput(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        totalCount = totalCount + 1;
        assert (obs === exp) passCount = passCount + 1;
        else begin
            failCount = failCount + 1;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        regWr = 1'b0; regSel = 3'd0; regData = 16'h0;
        memRd = 1'b0; memWr = 1'b0; memAddr = 16'h0; memRdata = 16'h0; memWdata = 16'h0;
        haltIn = 1'b0; icacheReq = 1'b0; icacheHit = 1'b0; dcacheReq = 1'b0; dcacheHit = 1'b0;
    endtask

    task automatic modelReset();
        expQ.delete();
        mState = M_RUN;
`ifdef TRACE_SUMMARY_EN
        for (int i = 0; i < 6; i++) mCnt[i] = 0;
        mDumpIdx = 0;
`endif
    endtask

    function automatic longint unsigned satInc(input longint unsigned v);
        return (v < 64'hFFFF_FFFF) ? v + 1 : v;
    endfunction

    // One clock cycle: compare DUT against the model, advance the model across the edge, move to the next negedge.
    task automatic applyStimulus();
        int          qs;
        int          prevState;
        logic        expStall;
        logic        smp;
        logic [35:0] head;
        qs        = expQ.size();
        prevState = mState;
        expStall  = (mState != M_RUN) || ((DEPTH - qs) < 4);
        head      = (qs > 0) ? expQ[0] : 36'h0;
        checkOutput("trace_valid", {35'h0, link.trace_valid}, {35'h0, qs > 0});
        checkOutput("trace_record", {link.trace_kind, link.trace_a, link.trace_b}, head);
        checkOutput("commit_stall", {35'h0, commitStall}, {35'h0, expStall});
        checkOutput("trace_done", {35'h0, traceDone}, {35'h0, mState == M_DONE});
        if (link.trace_valid && traceReady)
            rxLog.push_back({link.trace_kind, link.trace_a, link.trace_b});
        if (!rst_n) begin
            modelReset();
        end else begin
            smp = (mState == M_RUN) && !expStall;
            if ((qs > 0) && traceReady) void'(expQ.pop_front());
            if (smp) begin
                if (regWr)  expQ.push_back(rec(4'd0, {13'b0, regSel}, regData));
                if (memRd)  expQ.push_back(rec(4'd1, memAddr, memRdata));
                if (memWr)  expQ.push_back(rec(4'd2, memAddr, memWdata));
                if (haltIn) expQ.push_back(rec(4'd3, 16'h0, 16'h0));
            end
`ifdef TRACE_SUMMARY_EN
            if (prevState == M_RUN) mCnt[0] = satInc(mCnt[0]);
            if (smp && (haltIn || regWr || memWr)) mCnt[1] = satInc(mCnt[1]);
            if (smp && dcacheHit) mCnt[2] = satInc(mCnt[2]);
            if (smp && icacheHit) mCnt[3] = satInc(mCnt[3]);
            if (smp && dcacheReq) mCnt[4] = satInc(mCnt[4]);
            if (smp && icacheReq) mCnt[5] = satInc(mCnt[5]);
            if (prevState == M_DUMP && (DEPTH - qs) >= 1) begin
                expQ.push_back(rec(4'(4 + mDumpIdx), mCnt[mDumpIdx][31:16], mCnt[mDumpIdx][15:0]));
                if (mDumpIdx == 5) begin
                    mDumpIdx = 0;
                    mState   = M_DRAIN;
                end else begin
                    mDumpIdx = mDumpIdx + 1;
                end
            end
            if (smp && haltIn) mState = M_DUMP;
`else
            if (smp && haltIn) mState = M_DRAIN;
`endif
            if (prevState == M_DRAIN && qs == 0) mState = M_DONE;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios, then randomized traffic.
    initial begin
        passCount = 0; failCount = 0; totalCount = 0;
        idle();
        traceReady = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        modelReset();

        checkOutput("reset_valid", {35'h0, link.trace_valid}, 36'h0);
        checkOutput("reset_record", {link.trace_kind, link.trace_a, link.trace_b}, 36'h0);
        checkOutput("reset_stall", {35'h0, commitStall}, 36'h0);
        checkOutput("reset_done", {35'h0, traceDone}, 36'h0);
        applyStimulus();
        rst_n = 1'b1;

        $display("[TB] single register write record");
        traceReady = 1'b1;
        regWr = 1'b1; regSel = 3'd5; regData = 16'h1234;
        applyStimulus();
        idle();
        checkOutput("t1_valid", {35'h0, link.trace_valid}, 36'h1);
        checkOutput("t1_reg_rec", {link.trace_kind, link.trace_a, link.trace_b}, rec(4'd0, 16'h0005, 16'h1234));
        applyStimulus();

        $display("[TB] load with register write ordering");
        regWr = 1'b1; regSel = 3'd2; regData = 16'hBEEF;
        memRd = 1'b1; memAddr = 16'h0040; memRdata = 16'hBEEF;
        applyStimulus();
        idle();
        checkOutput("t2_first_reg", {link.trace_kind, link.trace_a, link.trace_b}, rec(4'd0, 16'h0002, 16'hBEEF));
        applyStimulus();
        checkOutput("t2_second_load", {link.trace_kind, link.trace_a, link.trace_b}, rec(4'd1, 16'h0040, 16'hBEEF));
        applyStimulus();
        applyStimulus();

        $display("[TB] backpressure fills the FIFO");
        traceReady = 1'b0;
        for (int i = 0; i < 7; i++) begin
            memWr = 1'b1; memAddr = 16'h0100 + 16'(i); memWdata = 16'hA000 + 16'(i);
            if (i == 4) checkOutput("t3_stall_after4", {35'h0, commitStall}, 36'h0);
            applyStimulus();
            if (i == 4) checkOutput("t3_stall_after5", {35'h0, commitStall}, 36'h1);
        end
        idle();
        traceReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3_store_order", {link.trace_kind, link.trace_a, link.trace_b},
                        rec(4'd2, 16'h0100 + 16'(i), 16'hA000 + 16'(i)));
            applyStimulus();
        end
        checkOutput("t3_empty", {35'h0, link.trace_valid}, 36'h0);
        applyStimulus();

        $display("[TB] halt after ten run cycles");
        rst_n = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
        rxLog.delete();
        for (int c = 1; c <= 10; c++) begin
            idle();
            icacheReq = 1'b1;
            icacheHit = (c <= 7);
            dcacheReq = (c == 3) || (c == 6);
            dcacheHit = (c == 6);
            regWr     = (c == 2) || (c == 5) || (c == 8);
            regSel    = 3'(c);
            regData   = 16'h1000 + 16'(c);
            haltIn    = (c == 10);
            applyStimulus();
        end
        idle();
        for (int n = 0; n < 60 && !traceDone; n++) applyStimulus();
        checkOutput("t4_done", {35'h0, traceDone}, 36'h1);
`ifdef TRACE_SUMMARY_EN
        checkOutput("t4_len", 36'(rxLog.size()), 36'd10);
        if (rxLog.size() == 10) begin
            checkOutput("t4_halt", rxLog[3], rec(4'd3, 16'h0, 16'h0));
            checkOutput("t4_cyc", rxLog[4], rec(4'd4, 16'h0, 16'd10));
            checkOutput("t4_inst", rxLog[5], rec(4'd5, 16'h0, 16'd4));
            checkOutput("t4_dchit", rxLog[6], rec(4'd6, 16'h0, 16'd1));
            checkOutput("t4_ichit", rxLog[7], rec(4'd7, 16'h0, 16'd7));
            checkOutput("t4_dcreq", rxLog[8], rec(4'd8, 16'h0, 16'd2));
            checkOutput("t4_icreq", rxLog[9], rec(4'd9, 16'h0, 16'd10));
        end
`else
        checkOutput("t4_len", 36'(rxLog.size()), 36'd4);
        if (rxLog.size() == 4) checkOutput("t4_last_halt", rxLog[3], rec(4'd3, 16'h0, 16'h0));
`endif

        $display("[TB] reset with records queued after halt");
        rst_n = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
        traceReady = 1'b0;
        regWr = 1'b1; regSel = 3'd1; regData = 16'h5555;
        memRd = 1'b1; memAddr = 16'h0200; memRdata = 16'h6666;
        applyStimulus();
        idle();
        haltIn = 1'b1;
        applyStimulus();
        idle();
        checkOutput("t5_queued_valid", {35'h0, link.trace_valid}, 36'h1);
        rst_n = 1'b0;
        applyStimulus();
        checkOutput("t5_flush_valid", {35'h0, link.trace_valid}, 36'h0);
        checkOutput("t5_flush_done", {35'h0, traceDone}, 36'h0);
        rst_n = 1'b1;
        rxLog.delete();
        traceReady = 1'b1;
        haltIn = 1'b1;
        applyStimulus();
        idle();
        for (int n = 0; n < 60 && !traceDone; n++) applyStimulus();
        checkOutput("t5_done", {35'h0, traceDone}, 36'h1);
`ifdef TRACE_SUMMARY_EN
        if (rxLog.size() >= 2) checkOutput("t5_cyc_restart", rxLog[1], rec(4'd4, 16'h0, 16'd1));
        else checkOutput("t5_len", 36'(rxLog.size()), 36'd7);
`else
        checkOutput("t5_len", 36'(rxLog.size()), 36'd1);
`endif

        $display("[TB] randomized traffic");
        rst_n = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
        for (int it = 0; it < 800; it++) begin
            regWr     = 1'($urandom_range(0, 1));
            regSel    = 3'($urandom);
            regData   = 16'($urandom);
            memRd     = 1'($urandom_range(0, 1));
            memWr     = 1'($urandom_range(0, 1));
            memAddr   = 16'($urandom);
            memRdata  = 16'($urandom);
            memWdata  = 16'($urandom);
            haltIn    = ($urandom_range(0, 59) == 0);
            icacheReq = 1'($urandom_range(0, 1));
            icacheHit = 1'($urandom_range(0, 1));
            dcacheReq = 1'($urandom_range(0, 1));
            dcacheHit = 1'($urandom_range(0, 1));
            traceReady = ((it % 100) < 20) ? 1'b0 : ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 199) != 0) && (mState != M_DONE);
            applyStimulus();
            rst_n = 1'b1;
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
